// File: rtl/spi_ram_ctrl_pkg.sv
// Shared types and constants for the SPI RAM command path: FSM states,
// command opcodes and field widths.
package spi_ram_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int OP_W   = 2;

    localparam logic [OP_W-1:0] OP_WR_ADDR = 2'b00;
    localparam logic [OP_W-1:0] OP_WR_DATA = 2'b01;
    localparam logic [OP_W-1:0] OP_RD_ADDR = 2'b10;
    localparam logic [OP_W-1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_CMD  = 3'd4,
        RD_WAIT = 3'd5,
        DONE    = 3'd6
    } state_e;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Requester and RAM-side bus of the SPI RAM arbiter; the arbiter takes the
// slave view, requesters plus the RAM take the master view.
interface spi_ram_arbiter_if
    import spi_ram_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = 8
);
    localparam int PL_W = (ADDR_SIZE > DATA_W) ? ADDR_SIZE : DATA_W;

    logic [1:0]             req;
    logic [1:0]             we;
    logic [2*ADDR_SIZE-1:0] addr;
    logic [2*DATA_W-1:0]    wdata;
    logic [1:0]             gnt;
    logic [1:0]             done;
    logic [DATA_W-1:0]      rdata;
    logic                   err;
    logic                   busy;
    logic [OP_W+PL_W-1:0]   ram_din;
    logic                   ram_rx_valid;
    logic [DATA_W-1:0]      ram_dout;
    logic                   ram_tx_valid;

    modport slave (
        input  req, we, addr, wdata, ram_dout, ram_tx_valid,
        output gnt, done, rdata, err, busy, ram_din, ram_rx_valid
    );

    modport master (
        output req, we, addr, wdata, ram_dout, ram_tx_valid,
        input  gnt, done, rdata, err, busy, ram_din, ram_rx_valid
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: combinational winner plus a registered pointer
// to the requester granted last (requester 1 out of reset).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       win,
    output logic       any
);
    logic last_r;

    // Winner selection: a tie goes to the requester not granted last
    always_comb begin
        any = |req;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_r;
            default: win = 1'b0;
        endcase
    end

    // Last-grant pointer, advanced only when the FSM accepts a request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (accept) begin
            last_r <= win;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Two-requester arbiter serialising read/write transactions onto a strobed
// RAM command port; reads wait a bounded time for the RAM response.
module spi_ram_arbiter
    import spi_ram_ctrl_pkg::*;
#(
    parameter int TIMEOUT   = 8,
    parameter int ADDR_SIZE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_ram_arbiter_if.slave bus
);
    localparam int PL_W  = (ADDR_SIZE > DATA_W) ? ADDR_SIZE : DATA_W;
    localparam int CMD_W = OP_W + PL_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e               state_r, state_nxt_s;
    logic                 idx_r, idx_nxt_s;
    logic [ADDR_SIZE-1:0] addr_r, addr_nxt_s;
    logic [DATA_W-1:0]    wdata_r, wdata_nxt_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
    logic [1:0]           gnt_r, gnt_nxt_s;
    logic [1:0]           done_r, done_nxt_s;
    logic [DATA_W-1:0]    rdata_r, rdata_nxt_s;
    logic                 err_r, err_nxt_s;
    logic                 busy_r;
    logic [CMD_W-1:0]     din_r, din_nxt_s;
    logic                 rxv_r, rxv_nxt_s;
    logic                 win_s, any_s, accept_s;
    logic                 req_we_s;
    logic [ADDR_SIZE-1:0] req_addr_s;
    logic [DATA_W-1:0]    req_wdata_s;

    function automatic logic [CMD_W-1:0] make_cmd(input logic [OP_W-1:0] op,
                                                   input logic [PL_W-1:0] payload);
        return {op, payload};
    endfunction

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (bus.req),
        .accept (accept_s),
        .win    (win_s),
        .any    (any_s)
    );

    // Fields of the current round-robin winner, latched on accept
    always_comb begin
        if (win_s) begin
            req_we_s    = bus.we[1];
            req_addr_s  = bus.addr[2*ADDR_SIZE-1:ADDR_SIZE];
            req_wdata_s = bus.wdata[2*DATA_W-1:DATA_W];
        end else begin
            req_we_s    = bus.we[0];
            req_addr_s  = bus.addr[ADDR_SIZE-1:0];
            req_wdata_s = bus.wdata[DATA_W-1:0];
        end
    end

    // Next state plus the outputs of that state, so every output is a flop
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        addr_nxt_s  = addr_r;
        wdata_nxt_s = wdata_r;
        cnt_nxt_s   = cnt_r;
        rdata_nxt_s = rdata_r;
        err_nxt_s   = err_r;
        gnt_nxt_s   = 2'b00;
        done_nxt_s  = 2'b00;
        din_nxt_s   = {CMD_W{1'b0}};
        rxv_nxt_s   = 1'b0;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    accept_s    = 1'b1;
                    idx_nxt_s   = win_s;
                    addr_nxt_s  = req_addr_s;
                    wdata_nxt_s = req_wdata_s;
                    err_nxt_s   = 1'b0;
                    gnt_nxt_s   = win_s ? 2'b10 : 2'b01;
                    rxv_nxt_s   = 1'b1;
                    if (req_we_s) begin
                        state_nxt_s = WR_ADDR;
                        din_nxt_s   = make_cmd(OP_WR_ADDR, PL_W'(req_addr_s));
                    end else begin
                        state_nxt_s = RD_ADDR;
                        din_nxt_s   = make_cmd(OP_RD_ADDR, PL_W'(req_addr_s));
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR_ADDR: begin
                state_nxt_s = WR_DATA;
                rxv_nxt_s   = 1'b1;
                din_nxt_s   = make_cmd(OP_WR_DATA, PL_W'(wdata_r));
            end
            WR_DATA: begin
                state_nxt_s = DONE;
                done_nxt_s  = idx_r ? 2'b10 : 2'b01;
            end
            RD_ADDR: begin
                state_nxt_s = RD_CMD;
                rxv_nxt_s   = 1'b1;
                din_nxt_s   = make_cmd(OP_RD_DATA, {PL_W{1'b0}});
            end
            RD_CMD: begin
                state_nxt_s = RD_WAIT;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
            RD_WAIT: begin
                // A response on the last allowed wait cycle still wins over the timeout
                if (bus.ram_tx_valid) begin
                    state_nxt_s = DONE;
                    rdata_nxt_s = bus.ram_dout;
                    err_nxt_s   = 1'b0;
                    done_nxt_s  = idx_r ? 2'b10 : 2'b01;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt_s = DONE;
                    rdata_nxt_s = {DATA_W{1'b0}};
                    err_nxt_s   = 1'b1;
                    done_nxt_s  = idx_r ? 2'b10 : 2'b01;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, latched request fields and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= 1'b0;
            addr_r  <= {ADDR_SIZE{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            gnt_r   <= 2'b00;
            done_r  <= 2'b00;
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            din_r   <= {CMD_W{1'b0}};
            rxv_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            addr_r  <= addr_nxt_s;
            wdata_r <= wdata_nxt_s;
            cnt_r   <= cnt_nxt_s;
            gnt_r   <= gnt_nxt_s;
            done_r  <= done_nxt_s;
            rdata_r <= rdata_nxt_s;
            err_r   <= err_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            din_r   <= din_nxt_s;
            rxv_r   <= rxv_nxt_s;
        end
    end

    assign bus.gnt          = gnt_r;
    assign bus.done         = done_r;
    assign bus.rdata        = rdata_r;
    assign bus.err          = err_r;
    assign bus.busy         = busy_r;
    assign bus.ram_din      = din_r;
    assign bus.ram_rx_valid = rxv_r;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter: behavioural RAM, transaction-level
// reference (memory image, round-robin pointer, latency rules), random traffic.
module tb_spi_ram_arbiter;

    localparam int TIMEOUT = 8;

    logic clk;
    logic rst_n;

    spi_ram_arbiter_if #(.ADDR_SIZE(8)) ifc ();

    spi_ram_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_SIZE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // RAM behavioural model (environment) and reference image (expectation)
    logic [7:0] ram_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ram_addr;
    bit         rd_pend;
    int         rd_cnt;
    int         resp_delay;
    logic [9:0] cmd_q [$];
    int         idle_din_bad;
    int         gnt_overlap;

    // Reference state: last-granted requester and last read result
    int         model_last;
    logic [7:0] model_rdata;

    task automatic step();
        @(negedge clk);
        ifc.ram_tx_valid = 1'b0;
        ifc.ram_dout     = 8'($urandom);
        if (rd_pend) begin
            if (rd_cnt == 0) begin
                ifc.ram_tx_valid = 1'b1;
                ifc.ram_dout     = ram_mem[ram_addr];
                rd_pend          = 1'b0;
            end else begin
                rd_cnt--;
            end
        end
        if (ifc.ram_rx_valid === 1'b1) begin
            cmd_q.push_back(ifc.ram_din);
            case (ifc.ram_din[9:8])
                2'b00: ram_addr = ifc.ram_din[7:0];
                2'b01: ram_mem[ram_addr] = ifc.ram_din[7:0];
                2'b10: ram_addr = ifc.ram_din[7:0];
                default: begin
                    if (resp_delay >= 0) begin
                        rd_pend = 1'b1;
                        rd_cnt  = resp_delay;
                    end
                end
            endcase
        end else if (ifc.ram_din !== 10'h000) begin
            idle_din_bad++;
        end
        if (ifc.gnt === 2'b11) gnt_overlap++;
    endtask

    task automatic apply_reset(input string name);
        rst_n     = 1'b0;
        ifc.req   = 2'b00;
        rd_pend   = 1'b0;
        step();
        step();
        n_tests++;
        if ({ifc.gnt, ifc.done, ifc.err, ifc.busy, ifc.ram_rx_valid, ifc.ram_din, ifc.rdata} !== 25'h0)
            begin n_fail++; $display("FAIL %s: outputs=%h expected all zero", name,
                {ifc.gnt, ifc.done, ifc.err, ifc.busy, ifc.ram_rx_valid, ifc.ram_din, ifc.rdata}); end
        rst_n       = 1'b1;
        model_last  = 1;
        model_rdata = 8'h00;
    endtask

    // One complete transaction from a single requester, checked end to end
    task automatic do_txn(input int who, input bit w, input logic [7:0] a, input logic [7:0] d,
                          input int delay, input bit skip_gap, input bit pulse_other);
        logic [1:0] oh;
        logic [9:0] exp0, exp1;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         exp_off, t, stray, other;
        bit         seen_done;
        oh    = (who == 1) ? 2'b10 : 2'b01;
        other = 1 - who;
        if (!skip_gap) begin
            step();
            n_tests++;
            if (ifc.busy !== 1'b0 || ifc.ram_rx_valid !== 1'b0) begin n_fail++;
                $display("FAIL idle_gap: busy=%b rx_valid=%b expected 0/0", ifc.busy, ifc.ram_rx_valid); end
        end
        cmd_q.delete();
        resp_delay = delay;
        ifc.req    = oh;
        ifc.we[who] = w;
        if (who == 1) begin ifc.addr[15:8] = a; ifc.wdata[15:8] = d; end
        else          begin ifc.addr[7:0]  = a; ifc.wdata[7:0]  = d; end
        step();
        n_tests++;
        if (ifc.gnt !== oh) begin n_fail++; $display("FAIL gnt: got %b expected %b", ifc.gnt, oh); end
        n_tests++;
        if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL busy_active: got %b expected 1", ifc.busy); end
        ifc.req   = 2'b00;
        ifc.we    = 2'($urandom);
        ifc.addr  = 16'($urandom);
        ifc.wdata = 16'($urandom);
        if (w) begin
            exp0 = {2'b00, a}; exp1 = {2'b01, d}; exp_off = 2; exp_err = 1'b0; exp_rd = model_rdata;
        end else begin
            exp0 = {2'b10, a}; exp1 = 10'h300;
            if (delay < 0) begin exp_off = TIMEOUT + 2; exp_err = 1'b1; exp_rd = 8'h00; end
            else           begin exp_off = delay + 3;   exp_err = 1'b0; exp_rd = ref_mem[a]; end
        end
        t = 0; stray = 0; seen_done = 1'b0;
        while (!seen_done && t < TIMEOUT + 12) begin
            step();
            t++;
            if (pulse_other && t == 1) begin
                ifc.req[other] = 1'b1;
                ifc.we[other]  = 1'b1;
            end else if (pulse_other && t == 2) begin
                ifc.req = 2'b00;
            end
            if (ifc.gnt !== 2'b00) stray++;
            if (ifc.done !== 2'b00) seen_done = 1'b1;
        end
        n_tests++;
        if (!seen_done || t != exp_off) begin n_fail++;
            $display("FAIL done_latency: got %0d (seen=%0b) expected %0d", t, seen_done, exp_off); end
        n_tests++;
        if (ifc.done !== oh) begin n_fail++; $display("FAIL done_idx: got %b expected %b", ifc.done, oh); end
        n_tests++;
        if (ifc.err !== exp_err) begin n_fail++; $display("FAIL err: got %b expected %b", ifc.err, exp_err); end
        n_tests++;
        if (ifc.rdata !== exp_rd) begin n_fail++; $display("FAIL rdata: got %h expected %h", ifc.rdata, exp_rd); end
        n_tests++;
        if (stray != 0) begin n_fail++; $display("FAIL stray_gnt: got %0d extra grants expected 0", stray); end
        n_tests++;
        if (cmd_q.size() != 2) begin n_fail++;
            $display("FAIL cmd_count: got %0d commands expected 2", cmd_q.size()); end
        else if (cmd_q[0] !== exp0 || cmd_q[1] !== exp1) begin n_fail++;
            $display("FAIL cmds: got %h,%h expected %h,%h", cmd_q[0], cmd_q[1], exp0, exp1); end
        if (w) ref_mem[a] = d;
        else   model_rdata = exp_rd;
        model_last = who;
    endtask

    task automatic test_reset();
        apply_reset("reset_state");
    endtask

    task automatic test_single_write();
        do_txn(0, 1'b1, 8'h3C, 8'hA5, 0, 1'b0, 1'b0);
    endtask

    task automatic test_read_back();
        do_txn(0, 1'b1, 8'h10, 8'h5A, 0, 1'b0, 1'b0);
        do_txn(1, 1'b0, 8'h10, 8'h00, 0, 1'b0, 1'b0);
    endtask

    task automatic test_contention();
        int n, t, last_t, w;
        logic [1:0] exp_g;
        apply_reset("contention_reset");
        ifc.req   = 2'b11;
        ifc.we    = 2'b11;
        ifc.addr  = {8'h21, 8'h20};
        ifc.wdata = {8'hB1, 8'hB0};
        n = 0; t = 0; last_t = -1;
        while (n < 4 && t < 40) begin
            step();
            t++;
            if (ifc.gnt !== 2'b00) begin
                w     = 1 - model_last;
                exp_g = (w == 1) ? 2'b10 : 2'b01;
                n_tests++;
                if (ifc.gnt !== exp_g) begin n_fail++;
                    $display("FAIL rr_order: grant %0d got %b expected %b", n, ifc.gnt, exp_g); end
                if (last_t >= 0) begin
                    n_tests++;
                    if (t - last_t != 4) begin n_fail++;
                        $display("FAIL back_to_back: gap %0d expected 4", t - last_t); end
                end
                ref_mem[8'h20 + 8'(w)] = (w == 1) ? 8'hB1 : 8'hB0;
                model_last = w;
                last_t     = t;
                n++;
            end
        end
        n_tests++;
        if (n != 4) begin n_fail++; $display("FAIL rr_count: got %0d grants expected 4", n); end
        ifc.req = 2'b00;
        t = 0;
        do begin step(); t++; end while (ifc.busy !== 1'b0 && t < 20);
        n_tests++;
        if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL drain: busy=%b expected 0", ifc.busy); end
    endtask

    task automatic test_timeout();
        do_txn(1, 1'b0, 8'h3C, 8'h00, -1, 1'b0, 1'b0);
        do_txn(0, 1'b1, 8'h3C, 8'h11, 0, 1'b0, 1'b0);
        do_txn(0, 1'b0, 8'h3C, 8'h00, 2, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        apply_reset("mid_op_pre_reset");
        ifc.req   = 2'b11;
        ifc.we    = 2'b01;
        ifc.addr  = {8'h10, 8'h40};
        ifc.wdata = {8'h00, 8'h77};
        step();
        n_tests++;
        if (ifc.gnt !== 2'b01) begin n_fail++; $display("FAIL mid_op_gnt: got %b expected 01", ifc.gnt); end
        ifc.req = 2'b10;
        step();
        rst_n = 1'b0;
        step();
        n_tests++;
        if (ifc.done !== 2'b00) begin n_fail++; $display("FAIL mid_op_done: got %b expected 00", ifc.done); end
        n_tests++;
        if ({ifc.gnt, ifc.err, ifc.busy, ifc.ram_rx_valid, ifc.ram_din, ifc.rdata} !== 23'h0) begin n_fail++;
            $display("FAIL mid_op_outputs: got %h expected 0",
                {ifc.gnt, ifc.err, ifc.busy, ifc.ram_rx_valid, ifc.ram_din, ifc.rdata}); end
        ref_mem[8'h40] = 8'h77;
        rst_n       = 1'b1;
        rd_pend     = 1'b0;
        model_last  = 1;
        model_rdata = 8'h00;
        do_txn(1, 1'b0, 8'h10, 8'h00, 0, 1'b1, 1'b0);
    endtask

    task automatic test_cancel();
        int stray;
        do_txn(1, 1'b0, 8'h10, 8'h00, 3, 1'b0, 1'b1);
        cmd_q.delete();
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ifc.gnt !== 2'b00) stray++;
        end
        n_tests++;
        if (stray != 0 || cmd_q.size() != 0) begin n_fail++;
            $display("FAIL cancel: grants=%0d cmds=%0d expected 0/0", stray, cmd_q.size()); end
    endtask

    task automatic test_random();
        int who, dly;
        bit w;
        logic [7:0] a, d;
        for (int i = 0; i < 40; i++) begin
            who = $urandom_range(0, 1);
            w   = 1'($urandom_range(0, 1));
            a   = 8'($urandom_range(0, 15));
            d   = 8'($urandom);
            dly = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, TIMEOUT - 1)) : -1;
            do_txn(who, w, a, d, dly, 1'b0, 1'b0);
        end
    endtask

    task automatic test_invariants();
        n_tests++;
        if (idle_din_bad != 0) begin n_fail++;
            $display("FAIL idle_din: %0d cycles with ram_din!=0 and no strobe, expected 0", idle_din_bad); end
        n_tests++;
        if (gnt_overlap != 0) begin n_fail++;
            $display("FAIL gnt_onehot: %0d cycles with both grants, expected 0", gnt_overlap); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        ifc.req          = 2'b00;
        ifc.we           = 2'b00;
        ifc.addr         = 16'h0000;
        ifc.wdata        = 16'h0000;
        ifc.ram_tx_valid = 1'b0;
        ifc.ram_dout     = 8'h00;
        ram_addr         = 8'h00;
        rd_pend          = 1'b0;
        rd_cnt           = 0;
        resp_delay       = 0;
        idle_din_bad     = 0;
        gnt_overlap      = 0;
        model_last       = 1;
        model_rdata      = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_timeout();
        test_reset_mid_op();
        test_cancel();
        test_random();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 8, max RD_WAIT cycles awaiting ram_tx_valid.
REQ-002 Parameter: ADDR_SIZE, default 8, RAM address width.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req  in  2  per-requester transaction request, bit i = requester i.
REQ-006 we  in  2  per-requester op: 1 write, 0 read; valid while req[i]=1.
REQ-007 addr  in  16  {addr1,addr0}, 8-bit RAM address per requester.
REQ-008 wdata  in  16  {wdata1,wdata0}, 8-bit write data per requester.
REQ-009 gnt  out  2  one-cycle pulse: request i accepted, fields latched.
REQ-010 done  out  2  one-cycle pulse: transaction of requester i complete.
REQ-011 rdata  out  8  read data, valid only while a read's done pulse is high.
REQ-012 err  out  1  timeout flag, valid only with done.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 ram_din  out  10  RAM command {opcode[1:0], payload[7:0]}.
REQ-015 ram_rx_valid  out  1  RAM command strobe.
REQ-016 ram_dout  in  8  RAM read data.
REQ-017 ram_tx_valid  in  1  RAM read-data valid.

Function
REQ-018 FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, DONE.
REQ-019 IDLE: if any req bit set, latch the winner's index, we, addr and wdata, then go to WR_ADDR if we=1, else RD_ADDR.
REQ-020 Arbitration is round-robin: if both requests are set, the requester not granted last wins; if one is set, it wins.
REQ-021 gnt[winner] is high for exactly the first command cycle (WR_ADDR or RD_ADDR).
REQ-022 WR_ADDR drives ram_rx_valid=1 with ram_din={2'b00,addr}; the next state is WR_DATA.
REQ-023 WR_DATA drives ram_rx_valid=1 with ram_din={2'b01,wdata}; the next state is DONE.
REQ-024 RD_ADDR drives ram_rx_valid=1 with ram_din={2'b10,addr}; the next state is RD_CMD.
REQ-025 RD_CMD drives ram_rx_valid=1 with ram_din={2'b11,8'h00}; the next state is RD_WAIT and the timeout counter clears.
REQ-026 RD_WAIT, when ram_tx_valid=1: capture ram_dout into the rdata register, clear err, go to DONE.
REQ-027 RD_WAIT, when ram_tx_valid=0: increment the counter; once TIMEOUT cycles have elapsed, set rdata=0 and err=1, then go to DONE.
REQ-028 DONE drives done[latched index]=1 for one cycle, then returns to IDLE.
REQ-029 ram_rx_valid=0 and ram_din=10'h000 in IDLE, RD_WAIT and DONE.
REQ-030 Latency from the req-sampled IDLE cycle to done: write 3 cycles, read 4 cycles (plus wait cycles); at least one IDLE cycle separates transactions.
REQ-031 Requests arriving while busy=1 wait; they are not queued beyond the level req.
REQ-032 Requesters hold their fields stable until gnt. Deasserting req before gnt cancels the request with no RAM traffic.
REQ-033 The latched fields are immune to input changes after gnt.
REQ-034 rdata holds its last value between reads. Writes never change rdata.
REQ-035 err is 0 on every write done.

Reset
REQ-036 While rst_n=0 at posedge: state=IDLE; gnt, done, err, busy, ram_rx_valid, ram_din, rdata and the counter are 0; last-granted is requester 1, so requester 0 wins the first tie.
REQ-037 Reset mid-transaction aborts it with no done pulse; ram_rx_valid is 0 from the cycle after the reset edge.

Structure
REQ-038 A shared package spi_ram_ctrl_pkg holds the state enum, the opcode constants (OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11), and the address and data widths.
REQ-039 Sub-module rr_arb2 implements the two-way round-robin pick (combinational grant plus registered last-grant pointer); everything else stays in spi_ram_arbiter.

Verification
REQ-040 Single write: req=2'b01, we0=1, addr0=8'h3C, wdata0=8'hA5. Expect ram_din 10'h03C then 10'h1A5 on consecutive strobed cycles, gnt[0] with the first, done[0] two cycles later, err=0.
REQ-041 Read-back: write 8'h5A to 8'h10, then read 8'h10 from requester 1. Expect commands 10'h210 then 10'h300, then done[1] with rdata=8'h5A and err=0.
REQ-042 Contention: req=2'b11 held after reset. Expect grants in the order 0,1,0,1 and never two gnt bits high together.
REQ-043 Timeout: model holds ram_tx_valid=0 during a read. Expect done with err=1 and rdata=0 after exactly TIMEOUT wait cycles; the next IDLE accepts a new request.
REQ-044 Reset mid-op: rst_n=0 in WR_DATA. Expect no done pulse, all outputs 0 the next cycle, and a pending req served normally after release.
REQ-045 Cancel: req0 pulsed while busy and dropped before IDLE. Expect no gnt[0] and no RAM command for it.
